// File: rtl/chip8_block_xfer_engine.sv
// chip8_block_xfer_engine
// Multicycle sequencer for the CHIP-8 block instructions Fx55 (store V0..Vx),
// Fx65 (load V0..Vx) and Fx33 (BCD of Vx). A start/busy/done handshake
// replaces an externally driven step count. All outputs are decoded from the
// FSM state, so every strobe, address and data output is 0 outside an
// active step.
module chip8_block_xfer_engine #(
    parameter int NUM_REGS  = 16,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int I_W       = 16,
    parameter int I_AUTOINC = 0,
    localparam int RI_W     = $clog2(NUM_REGS)
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [RI_W-1:0]   x_idx,
    input  logic [I_W-1:0]    i_base,
    output logic              busy,
    output logic              done,
    output logic [RI_W-1:0]   reg_addr,
    input  logic [DATA_W-1:0] reg_readdata,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_writedata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              reg_I_we,
    output logic [I_W-1:0]    reg_I_writedata
);

    // One extra bit so the LOAD step counter can reach x_idx+1.
    localparam int CNT_W = RI_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_BCD_RD,
        S_BCD_WR,
        S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;

    logic [1:0]        op_p0;
    logic [RI_W-1:0]   x_p0;
    logic [ADDR_W-1:0] base_p0;
    logic [I_W-1:0]    ibase_p0;
    logic [CNT_W-1:0]  x_ext;

    logic [3:0]        bcd_h_p1, bcd_t_p1, bcd_o_p1;

    function automatic logic [3:0] bcd_hundreds(input logic [7:0] v);
        return 4'(v / 8'd100);
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [7:0] v);
        return 4'((v / 8'd10) % 8'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [7:0] v);
        return 4'(v % 8'd10);
    endfunction

    assign accept = (state == S_IDLE) && start;
    assign x_ext  = {1'b0, x_p0};

    // State and step counter; reset abandons any transfer in flight.
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operand capture at accepted start; held for the whole transfer.
    always_ff @(posedge cpu_clk) begin
        if (accept) begin
            op_p0    <= op;
            x_p0     <= x_idx;
            base_p0  <= i_base[ADDR_W-1:0];
            ibase_p0 <= i_base;
        end
    end

    // BCD digits of the source register, split in the read step.
    always_ff @(posedge cpu_clk) begin
        if (state == S_BCD_RD) begin
            bcd_h_p1 <= bcd_hundreds(reg_readdata[7:0]);
            bcd_t_p1 <= bcd_tens(reg_readdata[7:0]);
            bcd_o_p1 <= bcd_ones(reg_readdata[7:0]);
        end
    end

    // Next-state, counter and per-step bus outputs.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        busy            = 1'b0;
        done            = 1'b0;
        reg_addr        = '0;
        reg_we          = 1'b0;
        reg_writedata   = '0;
        mem_addr        = '0;
        mem_we          = 1'b0;
        mem_writedata   = '0;
        reg_I_we        = 1'b0;
        reg_I_writedata = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cnt_nxt = '0;
                    case (op)
                        2'd0:    state_nxt = S_STORE;
                        2'd1:    state_nxt = S_LOAD;
                        2'd2:    state_nxt = S_BCD_RD;
                        default: state_nxt = S_FIN;
                    endcase
                end
            end

            S_STORE: begin
                busy          = 1'b1;
                reg_addr      = cnt[RI_W-1:0];
                mem_addr      = base_p0 + ADDR_W'(cnt);
                mem_writedata = reg_readdata;
                mem_we        = 1'b1;
                if (cnt == x_ext) begin
                    state_nxt = S_FIN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            // Address for element j goes out in step j; its synchronous read
            // data lands in register j during step j+1.
            S_LOAD: begin
                busy = 1'b1;
                if (cnt <= x_ext) begin
                    mem_addr = base_p0 + ADDR_W'(cnt);
                end
                if (cnt != '0) begin
                    reg_addr      = RI_W'(cnt - CNT_W'(1));
                    reg_writedata = mem_readdata;
                    reg_we        = 1'b1;
                end
                if (cnt == x_ext + CNT_W'(1)) begin
                    state_nxt = S_FIN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_BCD_RD: begin
                busy      = 1'b1;
                reg_addr  = x_p0;
                cnt_nxt   = '0;
                state_nxt = S_BCD_WR;
            end

            S_BCD_WR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = base_p0 + ADDR_W'(cnt);
                case (cnt)
                    CNT_W'(0): mem_writedata = DATA_W'(bcd_h_p1);
                    CNT_W'(1): mem_writedata = DATA_W'(bcd_t_p1);
                    default:   mem_writedata = DATA_W'(bcd_o_p1);
                endcase
                if (cnt == CNT_W'(2)) begin
                    state_nxt = S_FIN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_FIN: begin
                done = 1'b1;
                if ((I_AUTOINC != 0) && (op_p0 == 2'd0 || op_p0 == 2'd1)) begin
                    reg_I_we        = 1'b1;
                    reg_I_writedata = ibase_p0 + I_W'(x_p0) + I_W'(1);
                end
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip8_block_xfer_engine.sv
// tb_chip8_block_xfer_engine
// Drives two engines (I auto-increment off and on) with identical stimulus,
// each attached to its own register file, memory and I register. A
// transaction-level reference model predicts memory, registers, I and the
// start-to-done latency.
module tb_chip8_block_xfer_engine;

    localparam int NR = 16;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int IW = 16;
    localparam int RW = 4;
    localparam int MEMSZ = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [RW-1:0] x_idx;
    logic [IW-1:0] i_base;

    logic          busy[2], done[2], reg_we[2], mem_we[2], reg_I_we[2];
    logic [RW-1:0] reg_addr[2];
    logic [DW-1:0] reg_rd[2], reg_wd[2], mem_wd[2], mem_rd[2];
    logic [AW-1:0] mem_addr[2];
    logic [IW-1:0] i_wd[2];

    logic [DW-1:0] mem [2][MEMSZ];
    logic [DW-1:0] regs[2][NR];
    logic [IW-1:0] ireg[2];

    logic          pre_we;
    logic [1:0]    pre_sel;
    logic [AW-1:0] pre_addr;
    logic [IW-1:0] pre_data;

    logic [DW-1:0] m_mem[MEMSZ];
    logic [DW-1:0] m_regs[NR];
    logic [IW-1:0] m_i[2];

    int n_checks = 0;
    int n_err    = 0;
    int mon_err  = 0;

    chip8_block_xfer_engine #(.I_AUTOINC(0)) u_dut0 (
        .cpu_clk(clk), .cpu_reset_n(rst_n), .start(start), .op(op),
        .x_idx(x_idx), .i_base(i_base), .busy(busy[0]), .done(done[0]),
        .reg_addr(reg_addr[0]), .reg_readdata(reg_rd[0]), .reg_we(reg_we[0]),
        .reg_writedata(reg_wd[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
        .mem_writedata(mem_wd[0]), .mem_readdata(mem_rd[0]),
        .reg_I_we(reg_I_we[0]), .reg_I_writedata(i_wd[0])
    );

    chip8_block_xfer_engine #(.I_AUTOINC(1)) u_dut1 (
        .cpu_clk(clk), .cpu_reset_n(rst_n), .start(start), .op(op),
        .x_idx(x_idx), .i_base(i_base), .busy(busy[1]), .done(done[1]),
        .reg_addr(reg_addr[1]), .reg_readdata(reg_rd[1]), .reg_we(reg_we[1]),
        .reg_writedata(reg_wd[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
        .mem_writedata(mem_wd[1]), .mem_readdata(mem_rd[1]),
        .reg_I_we(reg_I_we[1]), .reg_I_writedata(i_wd[1])
    );

    assign reg_rd[0] = regs[0][reg_addr[0]];
    assign reg_rd[1] = regs[1][reg_addr[1]];

    // Register file, synchronous-read memory and I register for each engine.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) mem[d][mem_addr[d]] <= mem_wd[d];
            mem_rd[d] <= mem[d][mem_addr[d]];
            if (reg_we[d]) regs[d][reg_addr[d]] <= reg_wd[d];
            if (reg_I_we[d]) ireg[d] <= i_wd[d];
            if (pre_we) begin
                case (pre_sel)
                    2'd0:    mem[d][pre_addr] <= pre_data[DW-1:0];
                    2'd1:    regs[d][pre_addr[RW-1:0]] <= pre_data[DW-1:0];
                    default: ireg[d] <= pre_data;
                endcase
            end
        end
    end

    // Per-cycle invariants.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d] && reg_we[d]) mon_err++;
            if (busy[d] && done[d]) mon_err++;
            if (reg_I_we[d] && !done[d]) mon_err++;
        end
        if (reg_I_we[0]) mon_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Preload one location in both environments and in the model.
    task automatic poke(input logic [1:0] sel, input int addr, input logic [IW-1:0] data);
        pre_we = 1'b1; pre_sel = sel; pre_addr = AW'(addr); pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
        case (sel)
            2'd0:    m_mem[addr % MEMSZ] = data[DW-1:0];
            2'd1:    m_regs[addr % NR] = data[DW-1:0];
            default: begin m_i[0] = data; m_i[1] = data; end
        endcase
    endtask

    task automatic model_apply(input logic [1:0] o, input int x, input logic [IW-1:0] ib);
        int b;
        int v;
        b = int'(ib) % MEMSZ;
        case (o)
            2'd0: for (int k = 0; k <= x; k++) m_mem[(b + k) % MEMSZ] = m_regs[k];
            2'd1: for (int k = 0; k <= x; k++) m_regs[k] = m_mem[(b + k) % MEMSZ];
            2'd2: begin
                v = int'(m_regs[x]);
                m_mem[b] = DW'(v / 100);
                m_mem[(b + 1) % MEMSZ] = DW'((v / 10) % 10);
                m_mem[(b + 2) % MEMSZ] = DW'(v % 10);
            end
            default: ;
        endcase
        if (o == 2'd0 || o == 2'd1) m_i[1] = IW'(int'(ib) + x + 1);
    endtask

    task automatic compare_state(input string tag);
        int mism;
        for (int d = 0; d < 2; d++) begin
            mism = 0;
            for (int a = 0; a < MEMSZ; a++) if (mem[d][a] !== m_mem[a]) mism++;
            chk({tag, "_mem"}, mism, 0);
            mism = 0;
            for (int r = 0; r < NR; r++) if (regs[d][r] !== m_regs[r]) mism++;
            chk({tag, "_regs"}, mism, 0);
            chk({tag, "_I"}, ireg[d], m_i[d]);
        end
    endtask

    // One transfer: pulse start, time it to done, then verify end state.
    // With glitch set, start is held high with junk operands while busy
    // and through the done cycle.
    task automatic run_xfer(input string tag, input logic [1:0] o, input int x,
                            input logic [IW-1:0] ib, input bit glitch);
        int lat;
        int n;
        int bad;
        bit seen;
        op = o; x_idx = RW'(x); i_base = ib; start = 1'b1;
        @(posedge clk); #1;
        model_apply(o, x, ib);
        lat = (o == 2'd0) ? x + 1 : (o == 2'd1) ? x + 2 : (o == 2'd2) ? 4 : 0;
        n = 0; bad = 0; seen = 1'b0;
        if (!glitch) start = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (glitch) begin
                op = 2'($urandom); x_idx = RW'($urandom); i_base = IW'($urandom);
            end
            if (done[0]) begin seen = 1'b1; break; end
            if (!busy[0] || !busy[1]) bad++;
            n++;
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_busy_during"}, bad, 0);
        chk({tag, "_done_both"}, done[1], 1);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, done[0], 0);
        chk({tag, "_idle_after"}, busy[0], 0);
        compare_state(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; x_idx = '0; i_base = '0; pre_we = 1'b0;
        pre_sel = '0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_mem_we", mem_we[0], 0);
        chk("rst_reg_we", reg_we[1], 0);
        chk("rst_I_we", reg_I_we[1], 0);
        chk("rst_mem_addr", mem_addr[0], 0);
        chk("rst_reg_addr", reg_addr[1], 0);
        chk("rst_mem_wd", mem_wd[0], 0);
        rst_n = 1'b1;

        for (int a = 0; a < MEMSZ; a++) poke(2'd0, a, IW'($urandom));
        for (int r = 0; r < NR; r++) poke(2'd1, r, IW'($urandom));
        poke(2'd2, 0, 16'h1234);

        // STORE V0..V3 to 0x300
        poke(2'd1, 0, 16'h11); poke(2'd1, 1, 16'h22);
        poke(2'd1, 2, 16'h33); poke(2'd1, 3, 16'h44);
        run_xfer("store", 2'd0, 3, 16'h0300, 1'b0);
        chk("store_m300", mem[0][12'h300], 8'h11);
        chk("store_m303", mem[0][12'h303], 8'h44);
        chk("store_I_kept", ireg[0], 16'h1234);

        // LOAD V0..V2 from 0x200, V3 must stay
        poke(2'd0, 12'h200, 16'hA0); poke(2'd0, 12'h201, 16'hB1);
        poke(2'd0, 12'h202, 16'hC2); poke(2'd1, 3, 16'h5A);
        run_xfer("load", 2'd1, 2, 16'h0200, 1'b0);
        chk("load_v0", regs[0][0], 8'hA0);
        chk("load_v2", regs[0][2], 8'hC2);
        chk("load_v3", regs[0][3], 8'h5A);

        // BCD of V7
        poke(2'd1, 7, 16'hFE);
        run_xfer("bcd254", 2'd2, 7, 16'h0400, 1'b0);
        chk("bcd254_h", mem[0][12'h400], 8'd2);
        chk("bcd254_t", mem[0][12'h401], 8'd5);
        chk("bcd254_o", mem[0][12'h402], 8'd4);
        poke(2'd1, 7, 16'h00);
        run_xfer("bcd0", 2'd2, 7, 16'h0400, 1'b0);
        chk("bcd0_o", mem[1][12'h402], 8'd0);
        poke(2'd1, 7, 16'h09);
        run_xfer("bcd9", 2'd2, 7, 16'h0400, 1'b0);
        chk("bcd9_t", mem[1][12'h401], 8'd0);
        chk("bcd9_o", mem[1][12'h402], 8'd9);

        // Address wrap with I auto-increment
        poke(2'd1, 0, 16'h6C); poke(2'd1, 1, 16'h7D);
        run_xfer("wrap", 2'd0, 1, 16'h0FFF, 1'b0);
        chk("wrap_mFFF", mem[1][12'hFFF], 8'h6C);
        chk("wrap_m000", mem[1][12'h000], 8'h7D);
        chk("wrap_I_inc", ireg[1], 16'h1001);
        chk("wrap_I_kept", ireg[0], 16'h1234);

        // Start re-pulsed while busy and in the done cycle, then reserved op
        run_xfer("hs", 2'd0, 4, IW'($urandom), 1'b1);
        run_xfer("rsvd", 2'd3, 5, IW'($urandom), 1'b0);
        run_xfer("single", 2'd1, 0, IW'($urandom), 1'b0);

        // Reset in STORE step k=2 of x_idx=5
        op = 2'd0; x_idx = 4'd5; i_base = 16'h0500; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy[0], 0);
        chk("mrst_mem_we", mem_we[0], 0);
        chk("mrst_mem_addr", mem_addr[1], 0);
        chk("mrst_mem_wd", mem_wd[1], 0);
        for (int k = 0; k < 2; k++) m_mem[12'h500 + k] = m_regs[k];
        @(posedge clk); #1;
        rst_n = 1'b1;
        compare_state("mrst");
        run_xfer("post_rst", 2'd0, 2, 16'h0600, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            run_xfer("rnd", 2'($urandom_range(0, 3)), int'($urandom_range(0, NR - 1)),
                     IW'($urandom), ($urandom_range(0, 3) == 0));
        end

        chk("monitor", mon_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
